// File: rtl/mmio_input_port_if.sv
// Core-side read bus for the memory-mapped input port.
interface mmio_input_port_if;
    logic [31:0] addr;
    logic        rd_en;
    logic        hit;
    logic [31:0] rd_data;
    logic        irq;

    modport master (output addr, output rd_en, input hit, input rd_data, input irq);
    modport slave  (input addr, input rd_en, output hit, output rd_data, output irq);
endinterface

// File: rtl/mmio_input_port.sv
// Memory-mapped input responder: synchronises and debounces switches/buttons,
// latches button press events and serves word reads from a 16-byte window.
module mmio_input_port #(
    parameter int unsigned N_SW       = 8,
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned SAMPLE_DIV = 250000,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_BTN-1:0] btn_raw,
    mmio_input_port_if.slave bus
);

    localparam int unsigned N_IN   = N_SW + N_BTN;
    localparam int unsigned PRE_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned RISE_W = 4;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_DIV - 1);

    logic [N_IN-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_IN-1:0]  sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [N_IN-1:0]  db_q, db_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [N_BTN-1:0] evt_q, evt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;

    logic              sample_tick;
    logic [N_BTN-1:0]  btn_rise;
    logic [RISE_W-1:0] rise_cnt;
    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W:0]    cnt_sum;
    logic              rd_hit;
    logic [1:0]        offset;
    logic              unused_addr_bits;

    assign offset           = bus.addr[3:2];
    assign bus.hit          = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign rd_hit           = bus.rd_en & bus.hit;
    assign bus.irq          = irq_q;
    assign unused_addr_bits = ^bus.addr[1:0];

    // Synchroniser, prescaler, debounce shifters and event/counter next-state.
    always_comb begin
        sync1_d     = {btn_raw, sw_raw};
        sync2_d     = sync1_q;
        sample_tick = (pre_q == PRE_LAST);
        pre_d       = sample_tick ? '0 : pre_q + PRE_W'(1);
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        db_d        = db_q;
        if (sample_tick) begin
            sh0_d = sync2_q;
            sh1_d = sh0_q;
            sh2_d = sh1_q;
            // all-ones sets, all-zeros clears, anything mixed holds
            db_d  = (sh0_q & sh1_q & sh2_q) | (db_q & (sh0_q | sh1_q | sh2_q));
        end

        btn_rise = db_d[N_IN-1:N_SW] & ~db_q[N_IN-1:N_SW];
        rise_cnt = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            rise_cnt = rise_cnt + RISE_W'(btn_rise[i]);
        end

        // clear-on-read takes effect first so a same-cycle press still lands
        evt_d    = ((rd_hit && offset == 2'd2) ? '0 : evt_q) | btn_rise;
        cnt_base = (rd_hit && offset == 2'd3) ? '0 : cnt_q;
        cnt_sum  = (CNT_W+1)'(cnt_base) + (CNT_W+1)'(rise_cnt);
        cnt_d    = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        irq_d    = |evt_d;
    end

    // Read data mux; zero outside the window.
    always_comb begin
        bus.rd_data = '0;
        if (bus.hit) begin
            case (offset)
                2'd0:    bus.rd_data = 32'(db_q[N_SW-1:0]);
                2'd1:    bus.rd_data = 32'(db_q[N_IN-1:N_SW]);
                2'd2:    bus.rd_data = 32'(evt_q);
                default: bus.rd_data = 32'(cnt_q);
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            db_q    <= '0;
            pre_q   <= '0;
            evt_q   <= '0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            db_q    <= db_d;
            pre_q   <= pre_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
        end
    end

endmodule

// File: tb/tb_mmio_input_port.sv
// Directed bench for mmio_input_port with a 4-cycle debounce sample period.
module tb_mmio_input_port;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_raw;
    logic [3:0] btn_raw;
    int         errors = 0;
    int         checks = 0;
    int         cyc;
    int         found;
    logic       bad;

    mmio_input_port_if bus_if ();

    mmio_input_port #(
        .N_SW      (8),
        .N_BTN     (4),
        .SAMPLE_DIV(4),
        .BASE_ADDR (BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sw_raw (sw_raw),
        .btn_raw(btn_raw),
        .bus    (bus_if)
    );

    always #10 clk = ~clk;

    // Clock edges since reset release; sample ticks land on multiples of 4.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [31:0] off, input string tag, input logic [31:0] exp);
        bus_if.addr = BASE + off;
        #1;
        check_eq(tag, bus_if.rd_data, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        sw_raw        = 8'hFF;
        btn_raw       = 4'hF;
        bus_if.addr   = BASE;
        bus_if.rd_en  = 1'b0;
        step(3);
        for (int o = 0; o < 4; o++) peek(32'(o * 4), $sformatf("rst_rd%0d", o), 32'h0);
        check_eq("rst_irq", 32'(bus_if.irq), 32'h0);

        // release with switches high, buttons low
        btn_raw = 4'h0;
        step();
        reset = 1'b0;
        bus_if.addr = BASE;
        found = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (found == 0 && bus_if.rd_data == 32'hFF) found = k;
        end
        check_eq("sw_state", bus_if.rd_data, 32'hFF);
        check_eq("sw_latency_in_range", 32'(found >= 14 && found <= 18), 32'h1);
        peek(32'h4, "btn_state_idle", 32'h0);
        peek(32'h8, "btn_evt_idle", 32'h0);
        peek(32'hC, "evt_cnt_idle", 32'h0);

        // bounce: toggle every 3 clk for 40 clk, then hold
        bus_if.addr = BASE + 32'h4;
        bad = 1'b0;
        for (int t = 0; t < 40; t++) begin
            btn_raw[0] = ((t / 3) % 2 == 0);
            step();
            if (bus_if.rd_data[0]) bad = 1'b1;
        end
        check_eq("bounce_no_change", 32'(bad), 32'h0);
        btn_raw[0] = 1'b1;
        for (int k = 0; k < 24; k++) step();
        check_eq("bounce_settled", bus_if.rd_data, 32'h1);
        step(20);
        peek(32'h8, "bounce_evt", 32'h1);
        peek(32'hC, "bounce_cnt", 32'h1);
        check_eq("bounce_irq", 32'(bus_if.irq), 32'h1);

        // clear-on-read of BTN_EVENT and EVT_CNT
        bus_if.rd_en = 1'b1;
        peek(32'h8, "cor_evt_pre", 32'h1);
        step();
        bus_if.rd_en = 1'b0;
        peek(32'h8, "cor_evt_post", 32'h0);
        check_eq("cor_irq", 32'(bus_if.irq), 32'h0);
        bus_if.rd_en = 1'b1;
        peek(32'hC, "cor_cnt_pre", 32'h1);
        step();
        bus_if.rd_en = 1'b0;
        peek(32'hC, "cor_cnt_post", 32'h0);

        // collisions: align to a sample tick so debounced rises land on known edges
        for (int k = 0; k < 4 && (cyc % 4) != 0; k++) step();
        btn_raw[2] = 1'b1;            // rises 16 edges later
        step(8);
        btn_raw[1] = 1'b1;            // rises 16 edges later
        step(15);
        bus_if.rd_en = 1'b1;
        peek(32'h8, "coll_evt_old", 32'h4);
        step();
        bus_if.rd_en = 1'b0;
        peek(32'h8, "coll_evt_new", 32'h2);
        check_eq("coll_irq", 32'(bus_if.irq), 32'h1);
        peek(32'hC, "coll_cnt_two", 32'h2);
        btn_raw[3] = 1'b1;
        step(15);
        bus_if.rd_en = 1'b1;
        peek(32'hC, "coll_cnt_old", 32'h2);
        step();
        bus_if.rd_en = 1'b0;
        peek(32'hC, "coll_cnt_new", 32'h1);
        peek(32'h8, "coll_evt_b13", 32'hA);

        // saturation: 300 clean presses on btn 0
        bus_if.addr = BASE + 32'hC;
        for (int p = 0; p < 300; p++) begin
            btn_raw[0] = 1'b0;
            step(20);
            btn_raw[0] = 1'b1;
            step(20);
            if (p == 99) check_eq("sat_cnt_101", bus_if.rd_data, 32'd101);
        end
        check_eq("sat_cnt_255", bus_if.rd_data, 32'd255);
        bus_if.rd_en = 1'b1;
        peek(32'hC, "sat_read", 32'd255);
        step();
        bus_if.rd_en = 1'b0;
        peek(32'hC, "sat_cleared", 32'h0);

        // decode: one past the window, then low address bits ignored
        bus_if.addr  = BASE + 32'h10;
        bus_if.rd_en = 1'b1;
        #1;
        check_eq("dec_miss_hit", 32'(bus_if.hit), 32'h0);
        check_eq("dec_miss_data", bus_if.rd_data, 32'h0);
        step();
        bus_if.rd_en = 1'b0;
        bus_if.addr  = BASE + 32'hB;
        #1;
        check_eq("dec_hit", 32'(bus_if.hit), 32'h1);
        check_eq("dec_evt_kept", bus_if.rd_data, 32'hB);

        // reset with events pending wipes them
        reset = 1'b1;
        #1;
        check_eq("rst2_irq", 32'(bus_if.irq), 32'h0);
        peek(32'h8, "rst2_evt", 32'h0);
        peek(32'h4, "rst2_btn", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
